dispensador_producto: RTL and testbench
=======================================

Name: dispensador_producto

Overview:
- Downstream stage of the vending controller.
- Consumes the one-cycle product code that the controller emits on accept, and drives a per-slot motor for a fixed spin time.
- Confirms the drop through a product-fall sensor, retrying or flagging failure on timeout.
- Holds one pending request in a buffer while a dispense is in progress.

Parameters:
- T_GIRO, 50, motor-on cycles per spin attempt (>=1).
- T_ESPERA, 200, cycles to wait for the fall sensor after a spin (>=1).
- N_REINTENTOS, 1, extra spin attempts after the first timeout (0..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- producto  in  3  product code from the controller. Nonzero for one cycle = request; 0 = none.
- sensor_caida  in  1  fall sensor, asynchronous to clk, high while product passes.
- motor  out  5  one-hot slot motor drive; bit k-1 drives product k (k = 1..5).
- ocupado  out  1  high whenever the FSM is not in REPOSO.
- pendiente  out  1  high while the buffer holds a request.
- entregado  out  1  one-cycle pulse: drop confirmed.
- fallo  out  1  one-cycle pulse: all attempts timed out.
- descartado  out  1  one-cycle pulse: request dropped (buffer full or code 6/7).

Behaviour:
- Reset: all outputs 0, FSM = REPOSO, buffer empty, counters 0, sync flops 0.
  - Reset mid-dispense de-asserts motor immediately (asynchronous).
- Request validity:
  - Codes 1..5 are valid.
  - Codes 6 and 7 produce a descartado pulse the next cycle and no other effect.
- Request acceptance, in priority order each cycle:
  - FSM in REPOSO, buffer empty: the request is taken directly.
  - Otherwise, buffer empty: the request is stored and pendiente = 1 the next cycle.
  - Otherwise: descartado pulse the next cycle; the buffer is unchanged.
- Request timing: with producto valid at edge N, motor[k-1] = 1 from edge N+1.
- Sensor path:
  - 2-flop synchroniser, then rising-edge detect on the synchronised signal.
  - A sensor edge is recognised 2 edges after sensor_caida is first sampled high.
- FSM states:
  - REPOSO:
    - If the buffer is full, load its code; the buffer empties that cycle and the FSM enters GIRO.
    - Else, if a valid request is present, go to GIRO.
  - GIRO:
    - motor one-hot = current code; the counter counts T_GIRO cycles.
    - At terminal count, go to ESPERA_CAIDA with motor = 0.
  - ESPERA_CAIDA:
    - motor = 0; the counter counts T_ESPERA cycles.
    - At terminal count, if attempts remain, go to GIRO with a fresh T_GIRO.
    - At terminal count with no attempts left: fallo pulse, then REPOSO.
- Drop confirmation: a recognised sensor edge in GIRO or ESPERA_CAIDA means success.
  - motor = 0 on the next edge, entregado pulses on that same edge, and the FSM goes to REPOSO.
  - An edge on the same cycle as a timeout terminal count counts as success.
- Sensor edges in REPOSO are ignored.
- Attempt count: total attempts = 1 + N_REINTENTOS. The attempt counter clears on each new request.
- Back-to-back dispenses: REPOSO lasts exactly 1 cycle between them.
  - A buffered request leaves REPOSO on the first cycle the FSM is back in REPOSO.
  - A new request arriving in that same cycle goes into the freed buffer.
- Counter width: clog2 of max(T_GIRO, T_ESPERA). No wrap-around is possible.
- entregado, fallo and descartado are mutually exclusive per request, but may coincide across different requests. For example, descartado for a third request can pulse in the same cycle as entregado.

Decomposition:
- Shared package:
  - State encoding enum (REPOSO, GIRO, ESPERA_CAIDA).
  - Product code width (3) and slot count (5).
  - Code-to-one-hot decode function.
  - These are also used by the controller's bench.
- One natural sub-module: sincronizador_flanco (2-flop synchroniser plus rising-edge detect, 1-bit).

Test Plan (bench uses T_GIRO=4, T_ESPERA=8, N_REINTENTOS=1):
- Happy path:
  - Stimulus: producto=3 for 1 cycle at edge 10; sensor high at edge 16 for 2 cycles.
  - Required: motor=5'b00100 on edges 11-14; entregado pulse at edge 19; ocupado low at edge 19.
- Double timeout:
  - Stimulus: producto=1, no sensor.
  - Required: motor=5'b00001 for 4 cycles, off for 8, on for 4, off for 8; then fallo pulse, with 24 cycles total busy; no entregado.
- Retry success:
  - Stimulus: producto=2; sensor edge during the second GIRO.
  - Required: entregado pulses once; fallo never pulses; motor stops early.
- Buffering:
  - Stimulus: producto=4, then producto=5 during GIRO, then producto=1.
  - Required: pendiente=1; the code-1 request gives descartado; after the code-4 dispense, motor=5'b10000 follows after one REPOSO cycle.
- Invalid code:
  - Stimulus: producto=7 in REPOSO.
  - Required: descartado pulse next cycle; motor stays 0; ocupado stays 0.
- Reset mid-dispense:
  - Stimulus: reset asserted during GIRO with the buffer full.
  - Required: motor=0 and pendiente=0 immediately; after release, no dispense occurs.

Source files
------------

// File: rtl/dispensador_producto_pkg.sv
// Shared definitions for the product dispenser and the vending controller bench.
// Contents: FSM state encoding, product code width, slot count and the
// code-to-one-hot slot decode.
package dispensador_producto_pkg;

  localparam int W_CODIGO  = 3;
  localparam int N_RANURAS = 5;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    GIRO         = 2'd1,
    ESPERA_CAIDA = 2'd2
  } estado_t;

  // Codes 1..5 select slots 0..4; anything else drives no motor.
  function automatic logic [N_RANURAS-1:0] codigo_a_onehot(input logic [W_CODIGO-1:0] codigo);
    logic [N_RANURAS-1:0] r;
    r = '0;
    case (codigo)
      3'd1:    r = 5'b00001;
      3'd2:    r = 5'b00010;
      3'd3:    r = 5'b00100;
      3'd4:    r = 5'b01000;
      3'd5:    r = 5'b10000;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dispensador_producto_sincronizador_flanco.sv
// sincronizador_flanco: brings an asynchronous 1-bit input into the clk domain
// through two flops and flags its rising edge for exactly one cycle.
// Ports:
//   clk, reset (async, active-high)
//   i_dato   asynchronous input
//   o_flanco one-cycle pulse on a rising edge of the synchronised input
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic i_dato,
  output logic o_flanco
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_dato;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 only holds the previous synchronised value for edge detection.
  assign o_flanco = r_s2 & ~r_s3;

endmodule

// File: rtl/dispensador_producto.sv
// dispensador_producto: takes the one-cycle product code from the vending
// controller, spins the matching slot motor for T_GIRO cycles, then waits up to
// T_ESPERA cycles for the fall sensor. Retries N_REINTENTOS times before
// reporting a failure. One further request can be parked while busy.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   producto      request code (1..5 valid, 6/7 rejected, 0 = none)
//   sensor_caida  asynchronous fall sensor
//   motor         one-hot slot motor drive
//   ocupado       FSM not idle
//   pendiente     a request is parked
//   entregado     pulse: drop confirmed
//   fallo         pulse: every attempt timed out
//   descartado    pulse: request dropped
module dispensador_producto
  import dispensador_producto_pkg::*;
#(
  parameter int T_GIRO       = 50,
  parameter int T_ESPERA     = 200,
  parameter int N_REINTENTOS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_CODIGO-1:0]  producto,
  input  logic                 sensor_caida,
  output logic [N_RANURAS-1:0] motor,
  output logic                 ocupado,
  output logic                 pendiente,
  output logic                 entregado,
  output logic                 fallo,
  output logic                 descartado
);

  localparam int T_MAX = (T_GIRO > T_ESPERA) ? T_GIRO : T_ESPERA;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CW-1:0] FIN_GIRO   = CW'(T_GIRO - 1);
  localparam logic [CW-1:0] FIN_ESPERA = CW'(T_ESPERA - 1);
  localparam logic [1:0]    MAX_REINT  = 2'(N_REINTENTOS);

  estado_t             r_estado,    w_estado_sig;
  logic [CW-1:0]       r_cnt,       w_cnt_sig;
  logic [1:0]          r_intento,   w_intento_sig;
  logic [W_CODIGO-1:0] r_codigo,    w_codigo_sig;
  logic                r_buf_vld,   w_buf_vld_sig;
  logic [W_CODIGO-1:0] r_buf_cod,   w_buf_cod_sig;
  logic                r_entregado, w_entregado_sig;
  logic                r_fallo,     w_fallo_sig;
  logic                r_descartado, w_descartado_sig;

  logic w_flanco;
  logic w_req_inv;
  logic w_req_ok;
  logic w_directo;

  sincronizador_flanco u_sinc (
    .clk      (clk),
    .reset    (reset),
    .i_dato   (sensor_caida),
    .o_flanco (w_flanco)
  );

  assign w_req_inv = producto[2] & producto[1];
  assign w_req_ok  = (producto != '0) && !w_req_inv;

  // State register, counters, parked request and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado     <= REPOSO;
      r_cnt        <= '0;
      r_intento    <= '0;
      r_codigo     <= '0;
      r_buf_vld    <= 1'b0;
      r_buf_cod    <= '0;
      r_entregado  <= 1'b0;
      r_fallo      <= 1'b0;
      r_descartado <= 1'b0;
    end else begin
      r_estado     <= w_estado_sig;
      r_cnt        <= w_cnt_sig;
      r_intento    <= w_intento_sig;
      r_codigo     <= w_codigo_sig;
      r_buf_vld    <= w_buf_vld_sig;
      r_buf_cod    <= w_buf_cod_sig;
      r_entregado  <= w_entregado_sig;
      r_fallo      <= w_fallo_sig;
      r_descartado <= w_descartado_sig;
    end
  end

  // Next-state and request arbitration.
  always_comb begin
    w_estado_sig     = r_estado;
    w_cnt_sig        = r_cnt;
    w_intento_sig    = r_intento;
    w_codigo_sig     = r_codigo;
    w_buf_vld_sig    = r_buf_vld;
    w_buf_cod_sig    = r_buf_cod;
    w_entregado_sig  = 1'b0;
    w_fallo_sig      = 1'b0;
    w_descartado_sig = w_req_inv;
    w_directo        = 1'b0;

    case (r_estado)
      REPOSO: begin
        // A parked request always wins over a fresh one; sensor edges here are ignored.
        if (r_buf_vld) begin
          w_estado_sig  = GIRO;
          w_codigo_sig  = r_buf_cod;
          w_cnt_sig     = '0;
          w_intento_sig = '0;
          w_buf_vld_sig = 1'b0;
        end else if (w_req_ok) begin
          w_estado_sig  = GIRO;
          w_codigo_sig  = producto;
          w_cnt_sig     = '0;
          w_intento_sig = '0;
          w_directo     = 1'b1;
        end
      end
      GIRO: begin
        if (w_flanco) begin
          w_estado_sig    = REPOSO;
          w_entregado_sig = 1'b1;
        end else if (r_cnt == FIN_GIRO) begin
          w_estado_sig = ESPERA_CAIDA;
          w_cnt_sig    = '0;
        end else begin
          w_cnt_sig = r_cnt + CW'(1);
        end
      end
      ESPERA_CAIDA: begin
        // Sensor edge outranks the timeout on the same cycle.
        if (w_flanco) begin
          w_estado_sig    = REPOSO;
          w_entregado_sig = 1'b1;
        end else if (r_cnt == FIN_ESPERA) begin
          w_cnt_sig = '0;
          if (r_intento < MAX_REINT) begin
            w_estado_sig  = GIRO;
            w_intento_sig = r_intento + 2'd1;
          end else begin
            w_estado_sig = REPOSO;
            w_fallo_sig  = 1'b1;
          end
        end else begin
          w_cnt_sig = r_cnt + CW'(1);
        end
      end
      default: w_estado_sig = REPOSO;
    endcase

    // Anything not started directly tries the buffer; w_buf_vld_sig already
    // reflects a slot freed by REPOSO this cycle.
    if (w_req_ok && !w_directo) begin
      if (!w_buf_vld_sig) begin
        w_buf_vld_sig = 1'b1;
        w_buf_cod_sig = producto;
      end else begin
        w_descartado_sig = 1'b1;
      end
    end
  end

  // Outputs. motor is decoded from registers only, so reset clears it at once.
  always_comb begin
    motor = '0;
    if (r_estado == GIRO) motor = codigo_a_onehot(r_codigo);
    ocupado    = (r_estado != REPOSO);
    pendiente  = r_buf_vld;
    entregado  = r_entregado;
    fallo      = r_fallo;
    descartado = r_descartado;
  end

endmodule

// File: tb/tb_dispensador_producto.sv
// Bench for dispensador_producto: directed scenarios plus random traffic, with
// a timeline reference model feeding an expected-output queue and a monitor
// that pops and compares on every falling edge.
module tb_dispensador_producto;

  localparam int TG = 4;
  localparam int TE = 8;
  localparam int NR = 1;
  localparam int P  = TG + TE;
  localparam int D  = (1 + NR) * P;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] producto = 3'd0;
  logic       sensor_caida = 1'b0;
  logic [4:0] motor;
  logic       ocupado, pendiente, entregado, fallo, descartado;

  dispensador_producto #(
    .T_GIRO(TG), .T_ESPERA(TE), .N_REINTENTOS(NR)
  ) dut (
    .clk(clk), .reset(reset), .producto(producto), .sensor_caida(sensor_caida),
    .motor(motor), .ocupado(ocupado), .pendiente(pendiente),
    .entregado(entregado), .fallo(fallo), .descartado(descartado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] motor;
    logic       ocupado;
    logic       pendiente;
    logic       entregado;
    logic       fallo;
    logic       descartado;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Reference model: a dispense is a start edge plus arithmetic on elapsed
  // cycles; outcome is the first recognised sensor edge or the timeout at D.
  initial begin : model
    int         cyc;
    bit         m_busy, m_buf, rec, was_busy, was_buf;
    int         m_start;
    logic [2:0] m_code, m_bufc;
    bit         h1, h2, h3;
    obs_t       x;
    cyc = 0; m_busy = 0; m_buf = 0; m_start = 0; m_code = 0; m_bufc = 0;
    h1 = 0; h2 = 0; h3 = 0;
    forever begin
      @(posedge clk);
      cyc++;
      x = '0;
      if (reset) begin
        m_busy = 0; m_buf = 0; h1 = 0; h2 = 0; h3 = 0;
      end else begin
        // sensor sampled high two edges ago after being low three edges ago
        rec = h2 && !h3;
        h3 = h2; h2 = h1; h1 = sensor_caida;
        was_busy = m_busy;
        was_buf  = m_buf;
        if (was_busy) begin
          if (rec) begin
            x.entregado = 1'b1; m_busy = 0;
          end else if (cyc == m_start + D) begin
            x.fallo = 1'b1; m_busy = 0;
          end
        end
        if (!was_busy && was_buf) begin
          m_busy = 1; m_start = cyc; m_code = m_bufc; m_buf = 0;
        end
        if (producto >= 3'd6) x.descartado = 1'b1;
        else if (producto != 3'd0) begin
          if (!was_busy && !was_buf) begin
            m_busy = 1; m_start = cyc; m_code = producto;
          end else if (!m_buf) begin
            m_buf = 1; m_bufc = producto;
          end else x.descartado = 1'b1;
        end
        if (m_busy && ((cyc - m_start) % P) < TG) x.motor = 5'b00001 << (m_code - 3'd1);
        x.ocupado   = m_busy;
        x.pendiente = m_buf;
      end
      exp_q.push_back(x);
    end
  end

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {motor, ocupado, pendiente, entregado, fallo, descartado};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t: got mot=%b ocu=%b pen=%b ent=%b fal=%b des=%b, expected mot=%b ocu=%b pen=%b ent=%b fal=%b des=%b",
                   $time, a.motor, a.ocupado, a.pendiente, a.entregado, a.fallo, a.descartado,
                   e.motor, e.ocupado, e.pendiente, e.entregado, e.fallo, e.descartado);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue a one-cycle request; returns just after the sampling edge (j = 0).
  task automatic req(input logic [2:0] c);
    step(); producto = c;
    step(); producto = 3'd0;
  endtask

  task automatic esperar_reposo();
    int n;
    n = 0;
    while ((ocupado || pendiente) && n < 300) begin
      step(); n++;
    end
    chk("idle_wait_bound", int'(n < 300), 1);
    step();
  endtask

  initial begin : driver
    int busy, mon, nf, ne;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_motor", motor, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pendiente", pendiente, 0);
    reset = 1'b0;
    step(); step();

    // happy path
    req(3'd3);
    chk("hp_motor_j0", motor, 5'b00100);
    repeat (3) step();
    chk("hp_motor_j3", motor, 5'b00100);
    step();
    chk("hp_motor_off", motor, 0);
    step(); sensor_caida = 1'b1;
    step(); step(); sensor_caida = 1'b0;
    step();
    chk("hp_entregado", entregado, 1);
    chk("hp_ocupado", ocupado, 0);
    esperar_reposo();

    // double timeout
    req(3'd1);
    busy = 0; mon = 0; nf = 0; ne = 0;
    for (int i = 0; i < 60; i++) begin
      if (ocupado) busy++;
      if (motor == 5'b00001) mon++;
      if (fallo) nf++;
      if (entregado) ne++;
      step();
    end
    chk("dt_busy_cycles", busy, D);
    chk("dt_motor_cycles", mon, 2 * TG);
    chk("dt_fallo_count", nf, 1);
    chk("dt_entregado_count", ne, 0);

    // success during the second spin
    req(3'd2);
    repeat (11) step();
    sensor_caida = 1'b1;
    step(); step();
    chk("rs_motor_2nd_spin", motor, 5'b00010);
    sensor_caida = 1'b0;
    step();
    chk("rs_entregado", entregado, 1);
    chk("rs_motor_early_off", motor, 0);
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      if (fallo) nf++;
      step();
    end
    chk("rs_fallo_count", nf, 0);

    // buffering
    req(3'd4);
    step(); producto = 3'd5;
    step(); producto = 3'd1;
    chk("buf_pendiente", pendiente, 1);
    step(); producto = 3'd0;
    chk("buf_descartado", descartado, 1);
    repeat (21) step();
    chk("buf_fallo_first", fallo, 1);
    chk("buf_reposo_motor", motor, 0);
    step();
    chk("buf_second_motor", motor, 5'b10000);
    chk("buf_pendiente_clear", pendiente, 0);
    esperar_reposo();

    // invalid code
    req(3'd7);
    chk("inv_descartado", descartado, 1);
    chk("inv_ocupado", ocupado, 0);
    chk("inv_motor", motor, 0);
    step();

    // reset mid-dispense with a parked request
    req(3'd2);
    producto = 3'd5;
    step(); producto = 3'd0;
    chk("rm_pendiente_before", pendiente, 1);
    reset = 1'b1;
    #1;
    chk("rm_motor_async", motor, 0);
    chk("rm_pendiente_async", pendiente, 0);
    step(); step();
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (ocupado) busy++;
      step();
    end
    chk("rm_no_dispense", busy, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      producto = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (sensor_caida) sensor_caida = 1'($urandom_range(0, 1));
      else sensor_caida = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 599) == 0);
    end
    producto = 3'd0; sensor_caida = 1'b0; reset = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
